// File: rtl/pbuf_prog_pkg.sv
// Shared types and defaults for the pbuf configuration chain sequencer.
// Holds the sequencer state encoding and bit-timing helpers.
package pbuf_prog_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PH0,
    GAP0,
    PH1,
    GAP1,
    DONE
  } state_t;

  localparam int CHAIN_LEN_DEF = 6;
  localparam int SETUP_CYC_DEF = 1;
  localparam int PULSE_CYC_DEF = 1;
  localparam int GAP_CYC_DEF   = 1;

  // Clock cycles needed to move one bit through the chain.
  function automatic int t_bit(input int s, input int p, input int g);
    return s + 2 * p + 2 * g;
  endfunction

endpackage

// File: rtl/pbuf_phase_gen.sv
// One-bit shift timing: SETUP, PH0, GAP0, PH1, GAP1.
// Emits the two non-overlapping phase clocks plus sample/done strobes.
module pbuf_phase_gen
  import pbuf_prog_pkg::*;
#(
  parameter int SETUP_CYC = SETUP_CYC_DEF,
  parameter int PULSE_CYC = PULSE_CYC_DEF,
  parameter int GAP_CYC   = GAP_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic prog_clk0,
  output logic prog_clk1,
  output logic sample_stb,
  output logic bit_done
);

  localparam int MAX_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAXC   = (MAX_SP > GAP_CYC) ? MAX_SP : GAP_CYC;
  localparam int CW     = $clog2(MAXC + 1);

  state_t          st_q, st_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   lim;
  logic            last;
  logic            clk0_q, clk0_d;
  logic            clk1_q, clk1_d;

  // Dwell length of the current phase, minus one.
  always_comb begin
    lim = '0;
    unique case (st_q)
      SETUP:    lim = CW'(SETUP_CYC - 1);
      PH0, PH1: lim = CW'(PULSE_CYC - 1);
      GAP0,
      GAP1:     lim = CW'(GAP_CYC - 1);
      default:  lim = '0;
    endcase
  end

  assign last       = (cnt_q == lim);
  assign sample_stb = (st_q == SETUP) && last;
  assign bit_done   = (st_q == GAP1) && last;

  // Phase sequencing; GAP1 chains straight into the next bit on start.
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:    if (start) st_d = SETUP;
      SETUP:   if (last)  st_d = PH0;
      PH0:     if (last)  st_d = GAP0;
      GAP0:    if (last)  st_d = PH1;
      PH1:     if (last)  st_d = GAP1;
      GAP1:    if (last)  st_d = start ? SETUP : IDLE;
      default: st_d = IDLE;
    endcase
  end

  // Dwell counter restarts on every phase change.
  always_comb begin
    cnt_d = last ? '0 : cnt_q + 1'b1;
  end

  // Phase clocks registered from the next state so they never glitch.
  always_comb begin
    clk0_d = (st_d == PH0);
    clk1_d = (st_d == PH1);
  end

  // State, counter and phase clock registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q   <= IDLE;
      cnt_q  <= '0;
      clk0_q <= 1'b0;
      clk1_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      clk0_q <= clk0_d;
      clk1_q <= clk1_d;
    end
  end

  assign prog_clk0 = clk0_q;
  assign prog_clk1 = clk1_q;

endmodule

// File: rtl/pbuf_chain_prog.sv
// Serialises a config word MSB-first into a two-phase pbuf shift chain,
// capturing readback and optionally re-shifting to verify the chain.
module pbuf_chain_prog
  import pbuf_prog_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int SETUP_CYC = SETUP_CYC_DEF,
  parameter int PULSE_CYC = PULSE_CYC_DEF,
  parameter int GAP_CYC   = GAP_CYC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CHAIN_LEN-1:0] cfg_data,
  input  logic                 cfg_verify,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [CHAIN_LEN-1:0] rb_data,
  output logic                 prog_in,
  output logic                 prog_clk0,
  output logic                 prog_clk1,
  input  logic                 prog_out
);

  localparam int IW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(CHAIN_LEN - 1);

  // Top tracks IDLE / SETUP (shift in progress) / DONE; phases live below.
  state_t               st_q, st_d;
  logic [CHAIN_LEN-1:0] word_q, word_d;
  logic [CHAIN_LEN-1:0] rbs_q, rbs_d;
  logic [CHAIN_LEN-1:0] rb_q, rb_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 pass_q, pass_d;
  logic                 vfy_q, vfy_d;
  logic                 err_q, err_d;
  logic                 pin_q, pin_d;
  logic                 rdy_q, rdy_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 accept, start, last_bit, reshift;
  logic                 sample_stb, bit_done;

  assign accept   = cfg_valid && rdy_q;
  assign last_bit = (idx_q == '0);
  assign reshift  = bit_done && last_bit && !pass_q && vfy_q;
  assign start    = accept || (bit_done && (!last_bit || reshift));

  pbuf_phase_gen #(
    .SETUP_CYC (SETUP_CYC),
    .PULSE_CYC (PULSE_CYC),
    .GAP_CYC   (GAP_CYC)
  ) u_phase (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .prog_clk0  (prog_clk0),
    .prog_clk1  (prog_clk1),
    .sample_stb (sample_stb),
    .bit_done   (bit_done)
  );

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) st_q <= IDLE;
    else     st_q <= st_d;
  end

  // Next-state: run until the final pass ends, then one DONE cycle.
  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:    if (accept) st_d = SETUP;
      SETUP:   if (bit_done && last_bit && !reshift) st_d = DONE;
      DONE:    st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // Handshake outputs registered from the next state.
  always_comb begin
    rdy_d  = (st_d == IDLE);
    busy_d = (st_d != IDLE);
    done_d = (st_d == DONE);
  end

  // Word latch, bit index, readback capture and verify compare.
  always_comb begin
    word_d = word_q;
    vfy_d  = vfy_q;
    idx_d  = idx_q;
    pass_d = pass_q;
    err_d  = err_q;
    rbs_d  = rbs_q;
    rb_d   = rb_q;
    pin_d  = pin_q;
    if (accept) begin
      word_d = cfg_data;
      vfy_d  = cfg_verify;
      err_d  = 1'b0;
      idx_d  = IDX_TOP;
      pass_d = 1'b0;
      pin_d  = cfg_data[CHAIN_LEN-1];
    end
    if (sample_stb) begin
      rbs_d    = rbs_q << 1;
      rbs_d[0] = prog_out;
    end
    if (bit_done) begin
      if (!last_bit) begin
        idx_d = idx_q - 1'b1;
        pin_d = word_q[idx_d];
      end else if (reshift) begin
        rb_d   = rbs_q;
        pass_d = 1'b1;
        idx_d  = IDX_TOP;
        pin_d  = word_q[CHAIN_LEN-1];
      end else begin
        rb_d = rbs_q;
        if (vfy_q) err_d = (rbs_q != word_q);
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      vfy_q  <= 1'b0;
      idx_q  <= '0;
      pass_q <= 1'b0;
      err_q  <= 1'b0;
      rbs_q  <= '0;
      rb_q   <= '0;
      pin_q  <= 1'b0;
      rdy_q  <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      word_q <= word_d;
      vfy_q  <= vfy_d;
      idx_q  <= idx_d;
      pass_q <= pass_d;
      err_q  <= err_d;
      rbs_q  <= rbs_d;
      rb_q   <= rb_d;
      pin_q  <= pin_d;
      rdy_q  <= rdy_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign cfg_ready = rdy_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign rb_data   = rb_q;
  assign prog_in   = pin_q;

endmodule

// File: tb/tb_pbuf_chain_prog.sv
// Directed bench for pbuf_chain_prog with a two-latch chain model.
// Covers default timing and a stretched-timing instance.
module tb_pbuf_chain_prog;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [5:0] cfg_data = '0;
  logic       cfg_verify = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready, busy, done, err;
  logic [5:0] rb_data;
  logic       prog_in, prog_clk0, prog_clk1, prog_out;

  logic [5:0] d6 = '0;
  logic       v6 = 1'b0;
  logic       val6 = 1'b0;
  logic       rdy6, busy6, done6, err6;
  logic [5:0] rb6;
  logic       pin6, c0_6, c1_6, pout6;

  logic [5:0] m1 = '0, s1 = '0;
  logic [5:0] m6 = '0, s6 = '0;
  logic       fault = 1'b0;

  int         n_assert = 0;
  int         n_fail = 0;
  int         nb;
  logic       to;
  logic       pl [0:63];
  logic [5:0] seq, seq_end;
  logic       saw_done;

  int         quiet = 3;
  logic       pin_p, c0_p, c1_p;
  logic       pin6_p, c06_p, c16_p;

  always #5 clk = ~clk;

  pbuf_chain_prog u_dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_data   (cfg_data),
    .cfg_verify (cfg_verify),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .rb_data    (rb_data),
    .prog_in    (prog_in),
    .prog_clk0  (prog_clk0),
    .prog_clk1  (prog_clk1),
    .prog_out   (prog_out)
  );

  pbuf_chain_prog #(
    .CHAIN_LEN (6),
    .SETUP_CYC (2),
    .PULSE_CYC (3),
    .GAP_CYC   (2)
  ) u_dut6 (
    .clk        (clk),
    .rst        (rst),
    .cfg_data   (d6),
    .cfg_verify (v6),
    .cfg_valid  (val6),
    .cfg_ready  (rdy6),
    .busy       (busy6),
    .done       (done6),
    .err        (err6),
    .rb_data    (rb6),
    .prog_in    (pin6),
    .prog_clk0  (c0_6),
    .prog_clk1  (c1_6),
    .prog_out   (pout6)
  );

  // Two-latch chain models: clk0 loads masters, clk1 loads slaves.
  always @(posedge clk) begin
    if (prog_clk0) m1 <= {s1[4:0], prog_in};
    if (prog_clk1) s1 <= m1;
    if (c0_6) m6 <= {s6[4:0], pin6};
    if (c1_6) s6 <= m6;
  end

  assign prog_out = fault ? 1'b0 : s1[5];
  assign pout6    = s6[5];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Non-overlap and data-stable-under-clock monitors.
  always @(negedge clk) begin
    if (rst) quiet = 3;
    else if (quiet != 0) quiet--;
    if (quiet == 0) begin
      chk("overlap", 32'(prog_clk0 && prog_clk1), 32'd0);
      chk("overlap6", 32'(c0_6 && c1_6), 32'd0);
      if (prog_in !== pin_p)
        chk("pin_edge", 32'(prog_clk0 | prog_clk1 | c0_p | c1_p), 32'd0);
      if (pin6 !== pin6_p)
        chk("pin_edge6", 32'(c0_6 | c1_6 | c06_p | c16_p), 32'd0);
    end
    pin_p  = prog_in;
    c0_p   = prog_clk0;
    c1_p   = prog_clk1;
    pin6_p = pin6;
    c06_p  = c0_6;
    c16_p  = c1_6;
  end

  task automatic req(input logic [5:0] d, input logic v);
    @(negedge clk);
    cfg_data   = d;
    cfg_verify = v;
    cfg_valid  = 1'b1;
    @(negedge clk);
    cfg_valid  = 1'b0;
    cfg_data   = ~d;
    cfg_verify = ~v;
    nb = 0;
    to = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (k < 64) pl[k] = prog_in;
      if (done) begin
        to = 1'b0;
        break;
      end
      if (busy) nb++;
      @(negedge clk);
    end
    chk("req_timeout", 32'(to), 32'd0);
  endtask

  task automatic wait6();
    nb = 0;
    to = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (done6) begin
        to = 1'b0;
        break;
      end
      if (busy6) nb++;
      @(negedge clk);
    end
    chk("req6_timeout", 32'(to), 32'd0);
  endtask

  initial begin
    // 1. reset
    repeat (3) @(negedge clk);
    chk("rst_flags", 32'({cfg_ready, busy, done, err,
                          prog_in, prog_clk0, prog_clk1}), 32'b1000000);
    chk("rst_rb", 32'(rb_data), 32'd0);
    chk("rst_flags6", 32'({rdy6, busy6, done6, err6,
                           pin6, c0_6, c1_6}), 32'b1000000);
    rst = 1'b0;

    // 2. plain program 101010
    req(6'b101010, 1'b0);
    chk("t2_busy", 32'(nb), 32'd30);
    chk("t2_done_busy", 32'({done, busy}), 32'b11);
    seq     = {pl[0], pl[5], pl[10], pl[15], pl[20], pl[25]};
    seq_end = {pl[4], pl[9], pl[14], pl[19], pl[24], pl[29]};
    chk("t2_pin_seq", 32'(seq), 32'b101010);
    chk("t2_pin_hold", 32'(seq_end), 32'b101010);
    chk("t2_err", 32'(err), 32'd0);
    chk("t2_rb", 32'(rb_data), 32'd0);
    chk("t2_chain", 32'(s1), 32'b101010);
    @(negedge clk);
    chk("t2_pulse", 32'({done, busy, cfg_ready}), 32'b001);

    // 3. program then verify 110011
    req(6'b110011, 1'b0);
    chk("t3a_busy", 32'(nb), 32'd30);
    chk("t3a_rb", 32'(rb_data), 32'b101010);
    req(6'b110011, 1'b1);
    chk("t3b_busy", 32'(nb), 32'd60);
    chk("t3b_rb", 32'(rb_data), 32'b110011);
    chk("t3b_err", 32'(err), 32'd0);
    chk("t3b_chain", 32'(s1), 32'b110011);

    // 4. stuck-at-0 readback under verify
    fault = 1'b1;
    req(6'b111111, 1'b1);
    chk("t4_busy", 32'(nb), 32'd60);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_rb", 32'(rb_data), 32'd0);
    @(negedge clk);
    chk("t4_err_hold", 32'(err), 32'd1);
    fault = 1'b0;

    // 5. reset in the middle of a shift
    @(negedge clk);
    cfg_data   = 6'b010101;
    cfg_verify = 1'b1;
    cfg_valid  = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    repeat (11) @(negedge clk);
    chk("t5_pre_clk0", 32'(prog_clk0), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_flags", 32'({cfg_ready, busy, done, err,
                         prog_clk0, prog_clk1}), 32'b100000);
    chk("t5_rb", 32'(rb_data), 32'd0);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("t5_no_done", 32'(saw_done), 32'd0);
    req(6'b011001, 1'b1);
    chk("t5_busy", 32'(nb), 32'd60);
    chk("t5_rb_after", 32'(rb_data), 32'b011001);
    chk("t5_err_after", 32'(err), 32'd0);

    // 6. stretched timing, back-to-back with valid held high
    @(negedge clk);
    d6   = 6'b100110;
    v6   = 1'b0;
    val6 = 1'b1;
    @(negedge clk);
    d6 = 6'b011011;
    chk("t6_busy_start", 32'(busy6), 32'd1);
    wait6();
    chk("t6_busy1", 32'(nb), 32'd72);
    @(negedge clk);
    chk("t6_b2b_ready", 32'({rdy6, done6}), 32'b10);
    @(negedge clk);
    chk("t6_second_acc", 32'(busy6), 32'd1);
    val6 = 1'b0;
    wait6();
    chk("t6_busy2", 32'(nb), 32'd72);
    chk("t6_rb", 32'(rb6), 32'b100110);
    chk("t6_chain", 32'(s6), 32'b011011);
    chk("t6_err", 32'(err6), 32'd0);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
